// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Multiply/divide controller for the execute stage. It owns the HI/LO
// registers, runs MULT/MULTU/DIV/DIVU over a fixed number of busy cycles, and
// asks decode to stall while an MD instruction would collide with the unit.
//
// The arithmetic result is computed in the same cycle the operation is
// accepted and parked in a result buffer. The busy period only models the
// architectural latency. HI/LO are written when the countdown expires.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   start      : execute-stage instruction uses this unit this cycle
//   op         : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_val     : operand A (forwarded)
//   rt_val     : operand B (forwarded, before the ALU source mux)
//   d_uses_md  : decode-stage instruction touches HI/LO or the MD unit
//   busy       : a multiply/divide is in progress
//   stall      : hold decode
//   hi, lo     : architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_uses_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MUL_CNT = MUL_CYCLES[3:0];
   localparam logic [3:0] DIV_CNT = DIV_CYCLES[3:0];

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        res_wr_q, res_wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;

   // Two's-complement magnitude of a 32-bit value. The magnitude of 0x80000000
   // is 0x80000000, which is correct when read as unsigned.
   function automatic logic [31:0] mag32(input logic signed [31:0] v);
      logic [31:0] r;
      r = v[31] ? (~v + 32'd1) : v;
      return r;
   endfunction

   // Apply a sign to an unsigned magnitude.
   function automatic logic [31:0] apply_sign(input logic [31:0] m, input logic neg);
      logic [31:0] r;
      r = neg ? (~m + 32'd1) : m;
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Arithmetic
   // ------------------------------------------------------------------------
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_signed;
   logic        [31:0] dvd_mag, dvs_mag;
   logic        [31:0] uq, ur;
   logic        [31:0] quo, rem;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) *
                   $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   assign div_zero   = (rt_val == 32'd0);
   assign div_signed = (op == OP_DIV);

   // Signed division goes through an unsigned divider on magnitudes. This
   // handles 0x80000000 / -1 without overflow: the magnitude quotient is
   // 0x80000000, the signs match, and the remainder is 0.
   // The divisor is forced to 1 on divide-by-zero so the divider never sees
   // zero; that result is discarded anyway.
   always_comb begin
      dvd_mag = div_signed ? mag32(rs_val) : rs_val;
      dvs_mag = div_signed ? mag32(rt_val) : rt_val;
      if (div_zero) begin
         dvs_mag = 32'd1;
      end
      uq  = dvd_mag / dvs_mag;
      ur  = dvd_mag % dvs_mag;
      quo = div_signed ? apply_sign(uq, rs_val[31] ^ rt_val[31]) : uq;
      rem = div_signed ? apply_sign(ur, rs_val[31]) : ur;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_wr_d = res_wr_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     res_hi_d = prod_s[63:32];
                     res_lo_d = prod_s[31:0];
                     res_wr_d = 1'b1;
                     cnt_d    = MUL_CNT;
                     state_d  = RUN;
                  end
                  OP_MULTU: begin
                     res_hi_d = prod_u[63:32];
                     res_lo_d = prod_u[31:0];
                     res_wr_d = 1'b1;
                     cnt_d    = MUL_CNT;
                     state_d  = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     res_hi_d = rem;
                     res_lo_d = quo;
                     // Divide-by-zero still occupies the unit but leaves HI/LO alone.
                     res_wr_d = ~div_zero;
                     cnt_d    = DIV_CNT;
                     state_d  = RUN;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // start is ignored here; stall keeps decode from issuing.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = IDLE;
               if (res_wr_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         res_wr_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_wr_q <= res_wr_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Result buffer is pure data. It is only consumed when res_wr_q is set,
   // and res_wr_q is cleared by reset.
   always_ff @(posedge clk) begin
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy  = (state_q == RUN);
   // Stall when a mult/div is already in execute, so no MD op slips in behind it.
   assign stall = d_uses_md & (busy | (start & (op <= OP_DIVU)));
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_uses_md;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errs   = 0;

   logic [63:0] sb[$];

   mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .d_uses_md (d_uses_md),
      .busy      (busy),
      .stall     (stall),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Issues one mult/div, counts busy cycles, checks
   // stall every busy cycle, then pops the scoreboard and compares HI/LO.
   // With inj set, an MTHI is presented during RUN and must have no effect.
   task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int n,
                         input bit inj);
      int          cnt;
      bit          stall_bad;
      logic [31:0] hi_before;
      logic [63:0] e;
      sb.push_back(exp);
      hi_before = hi;
      start     = 1'b1;
      op        = o;
      rs_val    = a;
      rt_val    = b;
      d_uses_md = 1'b1;
      #1;
      check_eq({tag, "_stall_ex"}, 64'(stall), 64'd1);
      cnt       = 0;
      stall_bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
         if (stall !== 1'b1) stall_bad = 1'b1;
         if (inj && cnt == 3) check_eq({tag, "_hi_ignored"}, 64'(hi), 64'(hi_before));
         start  = inj && (cnt == 2);
         op     = (inj && cnt == 2) ? 3'd4 : o;
         rs_val = (inj && cnt == 2) ? 32'hDEADBEEF : a;
      end
      start = 1'b0;
      #1;
      check_eq({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
      check_eq({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
      check_eq({tag, "_stall_done"}, 64'(stall), 64'd0);
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_hilo"}, {hi, lo}, e);
      end
   endtask

   initial begin
      bit busy_seen;
      reset     = 1'b0;
      start     = 1'b0;
      op        = 3'd0;
      rs_val    = 32'd0;
      rt_val    = 32'd0;
      d_uses_md = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check_eq("rst_hilo", {hi, lo}, 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_stall", 64'(stall), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_rst_hilo", {hi, lo}, 64'd0);
      check_eq("post_rst_busy", 64'(busy), 64'd0);

      // MULT then MULTU back-to-back
      run_md("mult_m2x3", 3'd0, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5, 1'b0);
      run_md("multu_m2x3", 3'd1, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 5, 1'b0);

      // Divides, including an MTHI presented during RUN
      run_md("div_m7d2", 3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b1);
      run_md("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 1'b0);
      run_md("div_7dm2", 3'd2, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 10, 1'b0);
      run_md("divu_100d7", 3'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 10, 1'b0);
      run_md("divu_7d0", 3'd3, 32'd7, 32'd0, 64'h00000002_0000000E, 10, 1'b0);

      // Async reset in the third busy cycle of a DIV
      start  = 1'b1;
      op     = 3'd2;
      rs_val = 32'd1000;
      rt_val = 32'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("mid_busy_before", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      check_eq("mid_rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset     = 1'b1;
      busy_seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      check_eq("mid_rst_no_busy", 64'(busy_seen), 64'd0);
      check_eq("mid_rst_no_result", {hi, lo}, 64'd0);

      // MTHI then MTLO on consecutive cycles
      start  = 1'b1;
      op     = 3'd4;
      rs_val = 32'h12345678;
      #1;
      check_eq("mthi_stall", 64'(stall), 64'd0);
      @(negedge clk);
      check_eq("mthi_hi", 64'(hi), 64'h12345678);
      check_eq("mthi_lo", 64'(lo), 64'd0);
      check_eq("mthi_busy", 64'(busy), 64'd0);
      op     = 3'd5;
      rs_val = 32'h9ABCDEF0;
      @(negedge clk);
      check_eq("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
      check_eq("mtlo_busy", 64'(busy), 64'd0);

      // No-op code
      op     = 3'd6;
      rs_val = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
      check_eq("nop_busy", 64'(busy), 64'd0);
      check_eq("nop_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

      // Back-to-back MULTs
      run_md("mult_big", 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 5, 1'b0);
      run_md("mult_m1m1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 5, 1'b0);

      check_eq("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
